// File: rtl/shift_operand_stage.sv
// Operand-preparation stage for a funnel shifter: decodes opcode into (H, L, reverse)
// and holds bundles in a two-entry skid buffer. Define SHIFT_OPERAND_FUNNEL_EN to enable FSR/FSL.
module shift_operand_stage (
   input  logic        clk,
   input  logic        resetn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_op,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   input  logic [4:0]  in_shamt,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_h,
   output logic [31:0] out_l,
   output logic [4:0]  out_shamt,
   output logic        out_reverse,
   output logic        out_illegal
);

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned SHAMT_W = 5;
   localparam int unsigned OP_W    = 4;

   localparam logic [OP_W-1:0] OP_SRL = 4'd0;
   localparam logic [OP_W-1:0] OP_SRA = 4'd1;
   localparam logic [OP_W-1:0] OP_SLL = 4'd2;
   localparam logic [OP_W-1:0] OP_SRO = 4'd3;
   localparam logic [OP_W-1:0] OP_SLO = 4'd4;
   localparam logic [OP_W-1:0] OP_ROR = 4'd5;
   localparam logic [OP_W-1:0] OP_ROL = 4'd6;
   localparam logic [OP_W-1:0] OP_FSR = 4'd7;
   localparam logic [OP_W-1:0] OP_FSL = 4'd8;

   typedef struct packed {
      logic [DATA_W-1:0]  h;
      logic [DATA_W-1:0]  l;
      logic [SHAMT_W-1:0] shamt;
      logic               reverse;
      logic               illegal;
   } bundle_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t  state_q, state_d;
   bundle_t main_q, main_d;
   bundle_t skid_q, skid_d;
   bundle_t dec_c;
   logic    in_ready_q, in_ready_d;
   logic    out_valid_q, out_valid_d;
   logic    in_fire_c, out_fire_c;

`ifndef SHIFT_OPERAND_FUNNEL_EN
   logic unused_in_b;
   assign unused_in_b = ^in_b;
`endif

   // Opcode decode into the fill/data/direction triple; illegal opcodes zero the payload
   always_comb begin
      dec_c         = '0;
      dec_c.l       = in_a;
      dec_c.shamt   = in_shamt;
      case (in_op)
         OP_SRL: dec_c.h = '0;
         OP_SRA: dec_c.h = {DATA_W{in_a[DATA_W-1]}};
         OP_SLL: begin
            dec_c.h       = '0;
            dec_c.reverse = 1'b1;
         end
         OP_SRO: dec_c.h = '1;
         OP_SLO: begin
            dec_c.h       = '1;
            dec_c.reverse = 1'b1;
         end
         OP_ROR: dec_c.h = in_a;
         OP_ROL: begin
            dec_c.h       = in_a;
            dec_c.reverse = 1'b1;
         end
`ifdef SHIFT_OPERAND_FUNNEL_EN
         OP_FSR: dec_c.h = in_b;
         OP_FSL: begin
            dec_c.h       = in_b;
            dec_c.reverse = 1'b1;
         end
`endif
         default: begin
            dec_c         = '0;
            dec_c.illegal = 1'b1;
         end
      endcase
   end

   assign in_fire_c  = in_valid & in_ready_q;
   assign out_fire_c = out_valid_q & out_ready;

   // Skid-buffer next state; main always holds the oldest bundle
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         ST_EMPTY: begin
            if (in_fire_c) begin
               state_d = ST_ONE;
               main_d  = dec_c;
            end
         end
         ST_ONE: begin
            if (in_fire_c && out_fire_c) begin
               main_d = dec_c;
            end else if (in_fire_c) begin
               state_d = ST_TWO;
               skid_d  = dec_c;
            end else if (out_fire_c) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (out_fire_c) begin
               state_d = ST_ONE;
               main_d  = skid_q;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      in_ready_d  = (state_d != ST_TWO);
      out_valid_d = (state_d != ST_EMPTY);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= ST_EMPTY;
         main_q      <= '0;
         skid_q      <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_h       = main_q.h;
   assign out_l       = main_q.l;
   assign out_shamt   = main_q.shamt;
   assign out_reverse = main_q.reverse;
   assign out_illegal = main_q.illegal;

endmodule

// File: doc/shift_operand_stage.md
SHIFT_OPERAND_STAGE -- requirements
Module: shift_operand_stage

Interface
REQ-001 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-002 Port resetn  input  1  reset, synchronous, active-low.
REQ-003 Port in_valid  input  1  upstream request valid.
REQ-004 Port in_ready  output  1  stage can accept; registered output.
REQ-005 Port in_op  input  4  opcode: 0 SRL, 1 SRA, 2 SLL, 3 SRO, 4 SLO, 5 ROR, 6 ROL, 7 FSR, 8 FSL, 9-15 illegal.
REQ-006 Port in_a  input  32  primary operand A.
REQ-007 Port in_b  input  32  secondary operand B (funnel ops only).
REQ-008 Port in_shamt  input  5  shift amount.
REQ-009 Port out_valid  output  1  operand bundle valid to shifter.
REQ-010 Port out_ready  input  1  shifter accepts bundle.
REQ-011 Port out_h  output  32  high fill word H.
REQ-012 Port out_l  output  32  low data word L.
REQ-013 Port out_shamt  output  5  shift amount, passed unchanged.
REQ-014 Port out_reverse  output  1  left-shift (bit-reverse) select.
REQ-015 Port out_illegal  output  1  bundle carries an illegal opcode.

Function
REQ-016 Decode (H, L, reverse): SRL (0, A, 0); SRA ({32{A[31]}}, A, 0); SLL (0, A, 1); SRO (all-ones, A, 0); SLO (all-ones, A, 1); ROR (A, A, 0); ROL (A, A, 1); FSR (B, A, 0); FSL (B, A, 1).
REQ-017 Illegal opcode: bundle still transferred, H=0, L=0, shamt=0, reverse=0, out_illegal=1; legal opcodes give out_illegal=0.
REQ-018 Transfer in when in_valid&in_ready; out when out_valid&out_ready.
REQ-019 Decode happens before registering; output fields come straight from flops, no combinational path from in_* to out_*.
REQ-020 Two-entry skid buffer (main + skid register); states EMPTY, ONE, TWO.
REQ-021 EMPTY: input transfer -> ONE.
REQ-022 ONE: input only -> TWO; output only -> EMPTY; both -> ONE, main reloaded with new bundle.
REQ-023 TWO: output transfer -> ONE, skid moves to main; no input accepted.
REQ-024 in_ready=1 in EMPTY and ONE, 0 in TWO; out_valid=1 in ONE and TWO.
REQ-025 Latency 1 cycle: bundle accepted at edge N is on out_* after edge N, when ahead of it the buffer is empty.
REQ-026 Throughput one bundle/cycle when out_ready held high; strict FIFO order; no drop, no duplication.
REQ-027 out_* fields stay stable while out_valid=1 and out_ready=0.
REQ-028 in_* are ignored when in_ready=0, whatever in_valid is.

Reset
REQ-029 When resetn=0 at a clock edge: state EMPTY, out_valid=0, in_ready=0, out_h=0, out_l=0, out_shamt=0, out_reverse=0, out_illegal=0.
REQ-030 in_ready becomes 1 at the first edge where resetn=1.
REQ-031 Reset mid-operation discards both buffered bundles; handshakes in the reset cycle have no effect.

Configuration
REQ-032 Macro SHIFT_OPERAND_FUNNEL_EN defined: opcodes 7 (FSR) and 8 (FSL) decode per REQ-016.
REQ-033 Macro SHIFT_OPERAND_FUNNEL_EN undefined: opcodes 7 and 8 are illegal per REQ-017; in_b is unused.

Verification
REQ-034 Reset, then SRA with A=0x80000010, shamt=4, out_ready=1 -> next cycle out_h=0xFFFFFFFF, out_l=0x80000010, out_shamt=4, out_reverse=0, out_illegal=0.
REQ-035 ROL A=0x12345678, then SLO A=0x0000FFFF, back-to-back, out_ready=1 -> two consecutive outputs (H=L=0x12345678, rev=1), then (H=0xFFFFFFFF, L=0x0000FFFF, rev=1).
REQ-036 out_ready=0, push three bundles -> first two accepted, in_ready=0 after the second; raise out_ready -> bundles come out in order, outputs stable while stalled.
REQ-037 in_op=12, A=0xDEADBEEF, shamt=7 -> out_illegal=1, H=0, L=0, shamt=0, reverse=0.
REQ-038 FSL A=0x1, B=0x2, shamt=3 -> macro defined: H=0x2, L=0x1, rev=1, illegal=0; macro undefined: illegal=1.
REQ-039 Fill to TWO, assert resetn=0 for one cycle -> out_valid=0, in_ready=0; next cycle in_ready=1, no stale bundle appears.
